// File: rtl/multicycle_mem_unit_pkg.sv
// Shared definitions for the multicycle memory unit: FSM encodings, opcode field, defaults.
package mc_mem_defs;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;

    localparam int unsigned DefDepth = 256;
    localparam int unsigned DefLat   = 2;

    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/multicycle_mem_unit_if.sv
// Controller <-> memory unit bus. parity_inject exists only when MEM_PARITY_EN is defined.
interface multicycle_mem_unit_if;

    logic [31:0] pc_addr;
    logic [31:0] alu_addr;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] mdr;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;
`ifdef MEM_PARITY_EN
    logic        parity_inject;
`endif

    modport master (
`ifdef MEM_PARITY_EN
        output parity_inject,
`endif
        output pc_addr, alu_addr, IorD, MemRead, MemWrite, IRWrite, wdata,
        input  instr, opcode, mdr, mem_ready, mem_busy, mem_err
    );

    modport slave (
`ifdef MEM_PARITY_EN
        input  parity_inject,
`endif
        input  pc_addr, alu_addr, IorD, MemRead, MemWrite, IRWrite, wdata,
        output instr, opcode, mdr, mem_ready, mem_busy, mem_err
    );

endinterface

// File: rtl/multicycle_mem_unit_array.sv
// mc_mem_array: word array with synchronous write and combinational read of the same index.
// With MEM_PARITY_EN each word carries an even-parity bit checked on read.
module mc_mem_array
    import mc_mem_defs::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
`ifdef MEM_PARITY_EN
    input  logic              par_flip,
    output logic              par_err,
`endif
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[idx] <= even_parity(wdata) ^ par_flip;
        end
    end

    assign par_err = even_parity(rdata) ^ par_mem[idx];
`endif

endmodule

// File: rtl/multicycle_mem_unit.sv
// Unified I/D memory responder with IR/MDR and LAT-cycle ready handshake.
// Optional word parity checking enabled by MEM_PARITY_EN.
module multicycle_mem_unit
    import mc_mem_defs::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned LAT    = DefLat
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_mem_unit_if.slave bus
);

    localparam logic [3:0] LatInit = 4'(LAT - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              is_write_q;
    logic              irwrite_q;
    logic [31:0]       instr_q;
    logic [31:0]       mdr_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_q;

    logic [31:0] eff_addr;
    logic        req_any;
    logic        bad_req;
    logic        commit;
    logic        we;
    logic [31:0] rdata;
    logic        rd_par_err;

    assign eff_addr = bus.IorD ? bus.alu_addr : bus.pc_addr;
    assign req_any  = bus.MemRead | bus.MemWrite;
    assign bad_req  = (bus.MemRead & bus.MemWrite) | (eff_addr[1:0] != 2'b00)
                    | ((eff_addr >> (ADDR_W + 2)) != 32'd0);
    assign commit   = (state_q == StBusy) && (cnt_q == 4'd0);
    // Reset at the commit edge must discard the pending write.
    assign we       = commit && is_write_q && !rst;

`ifdef MEM_PARITY_EN
    logic par_inj_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_inj_q <= 1'b0;
        end else if (state_q == StIdle && req_any && !bad_req) begin
            par_inj_q <= bus.parity_inject;
        end
    end

    mc_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .we       (we),
        .idx      (idx_q),
        .wdata    (wdata_q),
        .par_flip (par_inj_q),
        .par_err  (rd_par_err),
        .rdata    (rdata)
    );
`else
    assign rd_par_err = 1'b0;

    mc_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            irwrite_q  <= 1'b0;
            instr_q    <= 32'd0;
            mdr_q      <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_any) begin
                        if (bad_req) begin
                            err_q <= 1'b1;
                        end else begin
                            idx_q      <= eff_addr[ADDR_W+1:2];
                            wdata_q    <= bus.wdata;
                            is_write_q <= bus.MemWrite;
                            irwrite_q  <= bus.IRWrite;
                            cnt_q      <= LatInit;
                            busy_q     <= 1'b1;
                            state_q    <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (commit) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                        if (!is_write_q) begin
                            mdr_q <= rdata;
                            err_q <= rd_par_err;
                            if (irwrite_q) begin
                                instr_q <= rdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instr     = instr_q;
    assign bus.opcode    = instr_q[OpcodeMsb:OpcodeLsb];
    assign bus.mdr       = mdr_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;

endmodule

// File: doc/multicycle_mem_unit.md
Name: multicycle_mem_unit

Overview:
- Unified instruction/data memory responder for the multicycle MIPS datapath.
- Serves the controller's IorD/MemRead/MemWrite/IRWrite requests and holds the Instruction Register (IR) and Memory Data Register (MDR).
- Returns the opcode back to the controller.
- Adds a configurable access latency with a ready handshake, so the controller can stall in its memory states.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of two).
- ADDR_W, 8, word-index width, log2(DEPTH).
- LAT, 2, cycles from request acceptance to completion (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_addr  in  32  byte address used when IorD=0
- alu_addr  in  32  byte address used when IorD=1
- IorD  in  1  address select
- MemRead  in  1  read request
- MemWrite  in  1  write request
- IRWrite  in  1  load IR with read data at completion
- wdata  in  32  write data (register B)
- instr  out  32  IR contents
- opcode  out  6  instr[31:26], feeds controller
- mdr  out  32  MDR contents
- mem_ready  out  1  one-cycle completion pulse
- mem_busy  out  1  access in progress
- mem_err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst=1 at a clk edge) sets: instr=0, mdr=0, mem_ready=0, mem_busy=0, mem_err=0, state=IDLE, latency counter=0.
  - Array contents are not reset.
  - Reset mid-access aborts the access; a pending write is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - MemRead xor MemWrite at an edge means the request is accepted.
  - Effective address = IorD ? alu_addr : pc_addr. Latch the address, wdata, the read/write kind and IRWrite.
  - Counter loads LAT-1; mem_busy=1 next cycle; go to BUSY.
- Request inputs are ignored while BUSY/DONE. Latched values are used, so the controller may change inputs after acceptance.
- BUSY:
  - Counter decrements each cycle.
  - When the counter reaches 0, the access commits at that edge:
    - Read: mdr <= array[idx]; if latched IRWrite, also instr <= array[idx].
    - Write: array[idx] <= latched wdata.
  - Go to DONE.
- DONE: mem_ready=1 and mem_busy=0 for exactly one cycle; return to IDLE.
  - A new request is accepted in IDLE no earlier than the cycle after DONE.
- Latency: a request sampled at edge N gives mem_ready high during cycle N+LAT+1. With LAT=1 this is the second cycle after the request edge.
- idx = effective_addr[ADDR_W+1:2].
- Error cases; each produces a mem_err pulse in the cycle after the request edge, no access, and the FSM stays in IDLE:
  - Misaligned address (addr[1:0]!=0).
  - Out of range (addr[31:ADDR_W+2]!=0).
  - MemRead and MemWrite both high.
- An error request has no effect on instr, mdr or the array, and mem_ready is not asserted.
- opcode is always instr[31:26] (combinational from IR).
- instr and mdr hold their values between accesses.
- Simultaneous rst with a request: reset wins and the request is dropped.

Optional Feature:
- Macro MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On read completion, a parity mismatch asserts mem_err in the same DONE cycle as mem_ready. mdr/instr are still loaded.
  - An extra input port parity_inject (1 bit, in) flips the stored parity bit on writes, for test.
- Not defined: no parity storage, no parity_inject port, and mem_err arises only from address/request errors.

Decomposition:
- Shared package/header mc_mem_defs holds:
  - FSM state encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - OPCODE field bounds (31:26).
  - Default DEPTH/LAT constants.
- One natural sub-module: mc_mem_array, a synchronous-write/read word array with DEPTH, ADDR_W and an optional parity bit.
- FSM, counter, IR and MDR stay in the top.

Test Plan:
- Preload word 0=0x8C220004 (lw). pc_addr=0, IorD=0, MemRead=1, IRWrite=1 with LAT=2 -> mem_ready pulses 3 cycles after the request edge; instr=0x8C220004, opcode=6'b100011, mdr=0x8C220004.
- Write then read: alu_addr=0x10, IorD=1, MemWrite=1, wdata=0xDEADBEEF; then MemRead at 0x10, IRWrite=0 -> mdr=0xDEADBEEF, instr unchanged.
- alu_addr=0x6 with MemRead -> mem_err pulse next cycle, mem_busy stays 0, mdr unchanged, no mem_ready.
- MemRead=MemWrite=1 -> mem_err pulse, array word unchanged on readback. alu_addr=0x400 (DEPTH=256) -> mem_err.
- Assert rst during BUSY of a write of 0x12345678 to 0x20 -> all outputs 0 next cycle; readback of 0x20 returns the old value.
- MEM_PARITY_EN: write 0xA5A5A5A5 with parity_inject=1, then read -> mem_err and mem_ready high in the same cycle, mdr=0xA5A5A5A5.
